// File: rtl/wb_stage_if.sv
// wb_stage_if: entry bundle from the memory stage and the write port
// towards the register file and forwarding unit.
interface wb_stage_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
);
   logic              in_valid;
   logic [1:0]        in_src;
   logic [DATA_W-1:0] in_alu;
   logic [DATA_W-1:0] in_mem;
   logic [DATA_W-1:0] in_link;
   logic [DATA_W-1:0] in_imm;
   logic [REG_AW-1:0] in_rd;
   logic              in_reg_we;
   logic              in_byte;
   logic              in_byte_hi;
   logic              in_signed;
   logic              in_halt;

   logic [DATA_W-1:0] wt_data;
   logic [REG_AW-1:0] wt_reg;
   logic              wt_en;
   logic              fwd_valid;

   // Memory-stage side: presents entries, observes the write port.
   modport master (
      output in_valid, in_src, in_alu, in_mem, in_link, in_imm, in_rd,
             in_reg_we, in_byte, in_byte_hi, in_signed, in_halt,
      input  wt_data, wt_reg, wt_en, fwd_valid
   );

   // Write-back stage side.
   modport slave (
      input  in_valid, in_src, in_alu, in_mem, in_link, in_imm, in_rd,
             in_reg_we, in_byte, in_byte_hi, in_signed, in_halt,
      output wt_data, wt_reg, wt_en, fwd_valid
   );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register with four-source result select,
// byte-load extension, single-fire writes under stall, halt sequencing
// and a retired-instruction counter.
module wb_stage #(
   parameter int DATA_W   = 16,
   parameter int REG_AW   = 3,
   parameter int CNT_W    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   wb_stage_if.slave        wb,
   output logic             halted,
   output logic [CNT_W-1:0] retire_cnt
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              v_q, v_d;
   logic              done_q, done_d;
   logic [1:0]        src_q, src_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [DATA_W-1:0] mem_q, mem_d;
   logic [DATA_W-1:0] link_q, link_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              we_q, we_d;
   logic              byte_q, byte_d;
   logic              byte_hi_q, byte_hi_d;
   logic              signed_q, signed_d;
   logic              halt_q, halt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              fire;
   logic              rd_blocked;
   logic [DATA_W-1:0] result;

   // Extend one byte lane to the datapath width, signed or unsigned.
   function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b,
                                                  input logic       sgn);
      logic signed [7:0] sb;
      sb = b;
      if (sgn) begin
         ext_byte = {{(DATA_W-8){sb[7]}}, b};
      end else begin
         ext_byte = {{(DATA_W-8){1'b0}}, b};
      end
   endfunction

   // Write qualification: an entry fires once, never while halting or halted.
   always_comb begin
      rd_blocked = (ZERO_REG != 0) && (rd_q == '0);
      fire       = v_q && !done_q && !halt_q && (state_q == RUN);
   end

   // Result select from the registered entry.
   always_comb begin
      result = alu_q;
      unique case (src_q)
         2'd0: result = alu_q;
         2'd1: begin
            if (!byte_q) begin
               result = mem_q;
            end else if (byte_hi_q) begin
               result = ext_byte(mem_q[15:8], signed_q);
            end else begin
               result = ext_byte(mem_q[7:0], signed_q);
            end
         end
         2'd2: result = link_q;
         2'd3: result = imm_q;
         default: result = alu_q;
      endcase
   end

   // Next-state: capture / hold / kill the entry, halt transition, retire count.
   always_comb begin
      state_d   = state_q;
      v_d       = v_q;
      done_d    = done_q;
      src_d     = src_q;
      alu_d     = alu_q;
      mem_d     = mem_q;
      link_d    = link_q;
      imm_d     = imm_q;
      rd_d      = rd_q;
      we_d      = we_q;
      byte_d    = byte_q;
      byte_hi_d = byte_hi_q;
      signed_d  = signed_q;
      halt_d    = halt_q;
      cnt_d     = cnt_q;

      if (state_q == HALTED) begin
         v_d    = 1'b0;
         done_d = 1'b0;
      end else begin
         if (v_q && !done_q && halt_q) begin
            state_d = HALTED;
         end
         if (flush) begin
            v_d    = 1'b0;
            done_d = 1'b0;
         end else if (stall) begin
            // Held entry: remember that its single write has happened.
            if (fire) begin
               done_d = 1'b1;
            end
         end else begin
            v_d       = wb.in_valid;
            done_d    = 1'b0;
            src_d     = wb.in_src;
            alu_d     = wb.in_alu;
            mem_d     = wb.in_mem;
            link_d    = wb.in_link;
            imm_d     = wb.in_imm;
            rd_d      = wb.in_rd;
            we_d      = wb.in_reg_we;
            byte_d    = wb.in_byte;
            byte_hi_d = wb.in_byte_hi;
            signed_d  = wb.in_signed;
            halt_d    = wb.in_halt;
         end
      end

      if (fire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State register; HALTED is left only through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Pipeline register and done flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q       <= 1'b0;
         done_q    <= 1'b0;
         src_q     <= '0;
         alu_q     <= '0;
         mem_q     <= '0;
         link_q    <= '0;
         imm_q     <= '0;
         rd_q      <= '0;
         we_q      <= 1'b0;
         byte_q    <= 1'b0;
         byte_hi_q <= 1'b0;
         signed_q  <= 1'b0;
         halt_q    <= 1'b0;
      end else begin
         v_q       <= v_d;
         done_q    <= done_d;
         src_q     <= src_d;
         alu_q     <= alu_d;
         mem_q     <= mem_d;
         link_q    <= link_d;
         imm_q     <= imm_d;
         rd_q      <= rd_d;
         we_q      <= we_d;
         byte_q    <= byte_d;
         byte_hi_q <= byte_hi_d;
         signed_q  <= signed_d;
         halt_q    <= halt_d;
      end
   end

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Write port and status outputs.
   always_comb begin
      wb.wt_data   = result;
      wb.wt_reg    = rd_q;
      wb.wt_en     = fire && we_q && !rd_blocked;
      wb.fwd_valid = v_q && we_q && !halt_q && !rd_blocked;
      halted       = (state_q == HALTED);
      retire_cnt   = cnt_q;
   end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven vectors for the result path plus directed
// sequences for stall, flush, zero register, halt and counter wrap.
module tb_wb_stage;

   logic       clk;
   logic       rst_n;
   logic       stall;
   logic       flush;
   logic       halted;
   logic [3:0] retire_cnt;

   wb_stage_if #(.DATA_W(16), .REG_AW(3)) bus ();

   wb_stage #(
      .DATA_W(16), .REG_AW(3), .CNT_W(4), .ZERO_REG(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .stall(stall),
      .flush(flush),
      .wb(bus),
      .halted(halted),
      .retire_cnt(retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  src;
      logic [15:0] alu;
      logic [15:0] mem;
      logic [15:0] link;
      logic [15:0] imm;
      logic [2:0]  rd;
      logic        we;
      logic        byt;
      logic        hi;
      logic        sgn;
      logic [15:0] exp_data;
      logic        exp_en;
      logic        exp_fwd;
   } vec_t;

   vec_t vecs[10];
   int   n_pass;
   int   n_total;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic valid, input logic [1:0] src,
                        input logic [15:0] alu, input logic [15:0] mem,
                        input logic [15:0] link, input logic [15:0] imm,
                        input logic [2:0] rd, input logic we, input logic byt,
                        input logic hi, input logic sgn, input logic halt);
      bus.in_valid   = valid;
      bus.in_src     = src;
      bus.in_alu     = alu;
      bus.in_mem     = mem;
      bus.in_link    = link;
      bus.in_imm     = imm;
      bus.in_rd      = rd;
      bus.in_reg_we  = we;
      bus.in_byte    = byt;
      bus.in_byte_hi = hi;
      bus.in_signed  = sgn;
      bus.in_halt    = halt;
   endtask

   task automatic drive_alu(input logic valid, input logic [15:0] alu,
                            input logic [2:0] rd, input logic we, input logic halt);
      drive(valid, 2'd0, alu, 16'h0, 16'h0, 16'h0, rd, we, 1'b0, 1'b0, 1'b0, halt);
   endtask

   task automatic idle();
      drive_alu(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      idle();
      stall = 1'b0;
      flush = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   function automatic vec_t mk(input logic [1:0] src, input logic [15:0] alu,
                               input logic [15:0] mem, input logic [15:0] link,
                               input logic [15:0] imm, input logic [2:0] rd,
                               input logic we, input logic byt, input logic hi,
                               input logic sgn, input logic [15:0] exp_data,
                               input logic exp_en, input logic exp_fwd);
      vec_t v;
      v.src = src; v.alu = alu; v.mem = mem; v.link = link; v.imm = imm;
      v.rd = rd; v.we = we; v.byt = byt; v.hi = hi; v.sgn = sgn;
      v.exp_data = exp_data; v.exp_en = exp_en; v.exp_fwd = exp_fwd;
      return v;
   endfunction

   initial begin
      n_pass  = 0;
      n_total = 0;

      //           src    alu       mem       link      imm       rd    we    byt   hi    sgn   data      en    fwd
      vecs[0] = mk(2'd0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1);
      vecs[1] = mk(2'd1, 16'h0000, 16'h80F7, 16'h0000, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFF7, 1'b1, 1'b1);
      vecs[2] = mk(2'd1, 16'h0000, 16'h80F7, 16'h0000, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0080, 1'b1, 1'b1);
      vecs[3] = mk(2'd1, 16'h0000, 16'h80F7, 16'h0000, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h80F7, 1'b1, 1'b1);
      vecs[4] = mk(2'd2, 16'h0000, 16'h0000, 16'h0042, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042, 1'b1, 1'b1);
      vecs[5] = mk(2'd3, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0);
      vecs[6] = mk(2'd0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      vecs[7] = mk(2'd1, 16'h0000, 16'h80F7, 16'h0000, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00F7, 1'b1, 1'b1);
      vecs[8] = mk(2'd1, 16'h0000, 16'h80F7, 16'h0000, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFF80, 1'b1, 1'b1);
      vecs[9] = mk(2'd0, 16'h0F0F, 16'h80F7, 16'h0000, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0F0F, 1'b1, 1'b1);

      idle();
      stall = 1'b0;
      flush = 1'b0;
      rst_n = 1'b0;
      repeat (2) step();

      chk("rst wt_en", 32'(bus.wt_en), 32'd0);
      chk("rst fwd_valid", 32'(bus.fwd_valid), 32'd0);
      chk("rst halted", 32'(halted), 32'd0);
      chk("rst wt_data", 32'(bus.wt_data), 32'd0);
      chk("rst wt_reg", 32'(bus.wt_reg), 32'd0);
      chk("rst retire_cnt", 32'(retire_cnt), 32'd0);
      rst_n = 1'b1;

      // Back-to-back table vectors: one capture and one retire per cycle.
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, vecs[i].src, vecs[i].alu, vecs[i].mem, vecs[i].link, vecs[i].imm,
               vecs[i].rd, vecs[i].we, vecs[i].byt, vecs[i].hi, vecs[i].sgn, 1'b0);
         step();
         chk($sformatf("vec%0d wt_data", i), 32'(bus.wt_data), 32'(vecs[i].exp_data));
         chk($sformatf("vec%0d wt_en", i), 32'(bus.wt_en), 32'(vecs[i].exp_en));
         chk($sformatf("vec%0d wt_reg", i), 32'(bus.wt_reg), 32'(vecs[i].rd));
         chk($sformatf("vec%0d fwd_valid", i), 32'(bus.fwd_valid), 32'(vecs[i].exp_fwd));
         chk($sformatf("vec%0d retire_cnt", i), 32'(retire_cnt), 32'(i & 15));
      end
      idle();
      step();
      chk("table final retire_cnt", 32'(retire_cnt), 32'd10);
      chk("table idle wt_en", 32'(bus.wt_en), 32'd0);

      // Stall: single write, forwarding held throughout.
      do_reset();
      drive_alu(1'b1, 16'hAAAA, 3'd6, 1'b1, 1'b0);
      step();
      chk("stall fire wt_en", 32'(bus.wt_en), 32'd1);
      chk("stall fire fwd", 32'(bus.fwd_valid), 32'd1);
      stall = 1'b1;
      drive_alu(1'b1, 16'h1111, 3'd1, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("stall%0d wt_en", k), 32'(bus.wt_en), 32'd0);
         chk($sformatf("stall%0d fwd", k), 32'(bus.fwd_valid), 32'd1);
         chk($sformatf("stall%0d wt_data", k), 32'(bus.wt_data), 32'hAAAA);
      end
      chk("stall retire_cnt", 32'(retire_cnt), 32'd1);
      stall = 1'b0;
      idle();
      step();
      chk("post-stall retire_cnt", 32'(retire_cnt), 32'd1);
      chk("post-stall fwd", 32'(bus.fwd_valid), 32'd0);

      // Flush beats stall and kills the incoming entry.
      drive_alu(1'b1, 16'h0BAD, 3'd5, 1'b1, 1'b0);
      step();
      chk("flush pre wt_en", 32'(bus.wt_en), 32'd1);
      stall = 1'b1;
      flush = 1'b1;
      drive_alu(1'b1, 16'h7777, 3'd4, 1'b1, 1'b0);
      step();
      chk("flush wt_en", 32'(bus.wt_en), 32'd0);
      chk("flush fwd", 32'(bus.fwd_valid), 32'd0);
      chk("flush retire_cnt", 32'(retire_cnt), 32'd2);
      stall = 1'b0;
      flush = 1'b0;
      idle();
      step();
      chk("after flush retire_cnt", 32'(retire_cnt), 32'd2);
      chk("after flush wt_en", 32'(bus.wt_en), 32'd0);

      // Register 0 write is suppressed but still retires.
      drive_alu(1'b1, 16'h9999, 3'd0, 1'b1, 1'b0);
      step();
      chk("r0 wt_en", 32'(bus.wt_en), 32'd0);
      chk("r0 fwd", 32'(bus.fwd_valid), 32'd0);
      idle();
      step();
      chk("r0 retire_cnt", 32'(retire_cnt), 32'd3);

      // Halt: no write, no retire, stays halted until reset.
      drive_alu(1'b1, 16'h2222, 3'd2, 1'b1, 1'b1);
      step();
      chk("halt entry wt_en", 32'(bus.wt_en), 32'd0);
      chk("halt entry fwd", 32'(bus.fwd_valid), 32'd0);
      chk("halt entry halted", 32'(halted), 32'd0);
      for (int k = 0; k < 3; k++) begin
         drive_alu(1'b1, 16'h3000 + 16'(k), 3'd3, 1'b1, 1'b0);
         step();
         chk($sformatf("halted%0d halted", k), 32'(halted), 32'd1);
         chk($sformatf("halted%0d wt_en", k), 32'(bus.wt_en), 32'd0);
         chk($sformatf("halted%0d retire_cnt", k), 32'(retire_cnt), 32'd3);
      end
      do_reset();
      chk("unhalt halted", 32'(halted), 32'd0);
      chk("unhalt retire_cnt", 32'(retire_cnt), 32'd0);
      drive_alu(1'b1, 16'h4321, 3'd5, 1'b1, 1'b0);
      step();
      chk("unhalt wt_en", 32'(bus.wt_en), 32'd1);
      chk("unhalt wt_data", 32'(bus.wt_data), 32'h4321);

      // Counter wrap with a 4-bit counter: 17 retires end at 1.
      do_reset();
      for (int k = 0; k < 17; k++) begin
         drive_alu(1'b1, 16'(k), 3'd1, 1'b1, 1'b0);
         step();
         if (k == 16) begin
            chk("wrap at 16 retire_cnt", 32'(retire_cnt), 32'd0);
         end
      end
      idle();
      step();
      chk("wrap final retire_cnt", 32'(retire_cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered write-back stage for the 16-bit CPU. It replaces the two-input ALU/memory result mux with a parametrised MEM/WB pipeline register, a four-source result select, byte-load extraction with sign/zero extension, stall/flush handling with single-fire write semantics, halt sequencing and a retired-instruction counter. It sits between the memory stage and the register file. Its write port also feeds the forwarding unit.

## Interface
Parameters:
- DATA_W, 16, datapath width; must be even, with at least 16 bits.
- REG_AW, 3, register address width.
- CNT_W, 32, retire counter width.
- ZERO_REG, 1, when 1 writes to register 0 are suppressed.

Ports (one clock; reset is asynchronous, active-low):
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream entry is valid.
- stall  in  1  hold the current entry; do not capture.
- flush  in  1  kill the current entry and the incoming entry.
- in_src  in  2  result source: 0=ALU, 1=MEM, 2=LINK, 3=IMM.
- in_alu, in_mem, in_link, in_imm  in  DATA_W each  candidate results.
- in_rd  in  REG_AW  destination register.
- in_reg_we  in  1  instruction writes the register file.
- in_byte  in  1  MEM source is a byte load.
- in_byte_hi  in  1  byte lane select: 1 = bits [15:8], 0 = bits [7:0].
- in_signed  in  1  byte load is sign-extended (else zero-extended).
- in_halt  in  1  instruction is HALT.
- wt_data  out  DATA_W  write data.
- wt_reg  out  REG_AW  write address.
- wt_en  out  1  register-file write strobe.
- fwd_valid  out  1  the held entry will write or has written; the forwarding unit may use wt_data.
- halted  out  1  core halted.
- retire_cnt  out  CNT_W  retired instruction count.

## Operation
- Pipeline register fields: v, src, alu, mem, link, imm, rd, we, byte, byte_hi, signed, halt. A done flag is kept alongside. The FSM has two states, RUN and HALTED.
- Capture at a rising edge in RUN:
  - flush=1: v←0 and done←0. Flush has priority over stall.
  - Otherwise, stall=1: all fields and done are held.
  - Otherwise: fields←inputs, v←in_valid, done←0.
- At a rising edge in HALTED: v←0 and done←0; inputs are ignored.
- Result mux (combinational from registered fields):
  - src 0 → alu; 2 → link; 3 → imm.
  - src 1, byte=0 → mem.
  - src 1, byte=1 → the selected byte lane, extended to DATA_W: sign-extended when signed=1, zero-extended otherwise.
- fire = v & ~done & ~halt & state==RUN. While stalled, an entry fires exactly once; done←1 at the edge closing the fire cycle.
- wt_en = fire & we & ~(ZERO_REG & rd==0).
- wt_reg = rd. wt_data = the mux result, always driven.
- fwd_valid = v & we & ~halt & ~(ZERO_REG & rd==0). It stays high through stall after firing.
- retire_cnt increments by 1 at the edge closing each fire cycle, whether or not the entry writes. It wraps modulo 2^CNT_W. HALT is not counted.
- Halt: when v & ~done & halt in RUN, the state becomes HALTED at the next edge. The halt entry never writes. HALTED is left only by reset.

## Timing
- Latency: an entry presented at edge N drives wt_en/wt_data during cycle N..N+1 and is written by the register file at edge N+1.
- Reset (asynchronous assert, synchronous release): v=0, done=0, all fields 0, state=RUN, retire_cnt=0. Outputs under reset: wt_en=0, fwd_valid=0, halted=0, wt_data=0, wt_reg=0.
- flush and stall together: flush wins.
- A flush while an entry is mid-stall after firing does not undo the write already performed.
- halted is registered; it rises one cycle after the halt entry is presented.
- Back-to-back entries with no stall: one write per cycle and one retire per cycle.
- Reset asserted mid-stall or while HALTED returns the stage to RUN with an empty register.

## Test plan
- ALU path: capture src=0, alu=0x1234, rd=3, we=1 → next cycle wt_en=1, wt_reg=3, wt_data=0x1234, retire_cnt 0→1.
- Byte loads, with mem=0x80F7:
  - byte=1, hi=0, signed=1 → wt_data=0xFFF7.
  - byte=1, hi=1, signed=0 → wt_data=0x0080.
  - byte=0 → wt_data=0x80F7.
- Stall single-fire: capture a writing entry, then hold stall=1 for 3 cycles → wt_en high in the first cycle only, fwd_valid high for all 4 cycles, retire_cnt +1.
- Flush priority: stall=1 and flush=1 together with a new valid input → v=0, no write, no retire on the following cycle.
- Zero register and halt:
  - rd=0, we=1, ZERO_REG=1 → wt_en=0, retire_cnt +1.
  - HALT entry followed by valid entries → halted=1 one cycle later, no further wt_en or retires until rst_n pulses low.
- Counter wrap (CNT_W=4): 17 back-to-back retiring entries → retire_cnt ends at 1.
